// File: rtl/decode_pkg.sv
// Shared types for the decode/issue stage:
// field positions, opcodes and the issue slot.
package decode_pkg;

  localparam int DW = 32;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 28;
  localparam int RD_HI  = 27;
  localparam int RD_LO  = 24;
  localparam int RS1_HI = 23;
  localparam int RS1_LO = 20;
  localparam int RS2_HI = 19;
  localparam int RS2_LO = 16;
  localparam int RS3_HI = 15;
  localparam int RS3_LO = 12;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_MUL  = 4'd9,
    OP_LUI  = 4'd10,
    OP_LD   = 4'd11,
    OP_ST   = 4'd12,
    OP_BR   = 4'd13,
    OP_NOP  = 4'd14,
    OP_HALT = 4'd15
  } op_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef struct packed {
    op_e           op;
    logic [3:0]    rd;
    logic          we;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [15:0]   imm;
  } issue_t;

  // Store, branch, nop and halt leave rd alone.
  function automatic logic writes_rd(op_e op);
    return op <= OP_LD;
  endfunction

endpackage

// File: rtl/decode_issue_scoreboard.sv
// Busy-bit scoreboard with writeback bypass on
// every lookup.
module scoreboard
  import decode_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rs1_i,
  input  logic [3:0] rs2_i,
  input  logic [3:0] rs3_i,
  input  logic [3:0] rd_i,
  input  logic       we_i,
  input  logic       wb_valid_i,
  input  logic [3:0] wb_rd_i,
  input  logic       set_i,
  input  logic [3:0] set_idx_i,
  input  logic       fclr_i,
  input  logic [3:0] fclr_idx_i,
  output logic       src_busy_o,
  output logic       waw_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  function automatic logic pend(
    logic [NREG-1:0] b,
    logic            v,
    logic [3:0]      w,
    logic [3:0]      i
  );
    return b[i] && !(v && w == i);
  endfunction

  // Lookups: a register retiring this cycle is free.
  always_comb begin
    src_busy_o =
      pend(busy_q, wb_valid_i, wb_rd_i, rs1_i) ||
      pend(busy_q, wb_valid_i, wb_rd_i, rs2_i) ||
      pend(busy_q, wb_valid_i, wb_rd_i, rs3_i);
    waw_o = we_i &&
      pend(busy_q, wb_valid_i, wb_rd_i, rd_i);
  end

  // Clear on writeback, clear on flush, then set.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i) busy_d[wb_rd_i] = 1'b0;
    if (fclr_i) busy_d[fclr_idx_i] = 1'b0;
    if (set_i) busy_d[set_idx_i] = 1'b1;
  end

  // Busy-bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: field decode, hazard stall,
// operand forwarding and a one-entry output slot.
module decode_issue
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_instr,
  output logic            in_ready,
  output logic [3:0]      rf_rs1,
  output logic [3:0]      rf_rs2,
  output logic [3:0]      rf_rs3,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic [XLEN-1:0] rf_rd3,
  output logic            rf_we,
  output logic [3:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic            wb_valid,
  input  logic [3:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_op,
  output logic [3:0]      out_rd,
  output logic            out_we,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [XLEN-1:0] out_c,
  output logic [15:0]     out_imm,
  output logic [15:0]     stall_cnt
);

  op_e        op;
  logic [3:0] rd;
  logic       we;
  logic       src_busy;
  logic       waw;
  logic       hazard;
  logic       issue;
  logic       fclr;

  state_e     state_q;
  state_e     state_d;
  issue_t     slot_q;
  issue_t     slot_d;
  logic [15:0] stall_q;
  logic [15:0] stall_d;

  assign op     = op_e'(in_instr[OP_HI:OP_LO]);
  assign rd     = in_instr[RD_HI:RD_LO];
  assign we     = writes_rd(op);
  assign rf_rs1 = in_instr[RS1_HI:RS1_LO];
  assign rf_rs2 = in_instr[RS2_HI:RS2_LO];
  assign rf_rs3 = in_instr[RS3_HI:RS3_LO];

  assign rf_we    = wb_valid;
  assign rf_waddr = wb_rd;
  assign rf_wdata = wb_data;

  assign out_valid = (state_q == FULL);
  assign fclr      = flush && out_valid && slot_q.we;

  scoreboard #(
    .NREG(NREG)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst),
    .rs1_i     (rf_rs1),
    .rs2_i     (rf_rs2),
    .rs3_i     (rf_rs3),
    .rd_i      (rd),
    .we_i      (we),
    .wb_valid_i(wb_valid),
    .wb_rd_i   (wb_rd),
    .set_i     (issue && we),
    .set_idx_i (rd),
    .fclr_i    (fclr),
    .fclr_idx_i(slot_q.rd),
    .src_busy_o(src_busy),
    .waw_o     (waw)
  );

  // Handshake: stall on hazard, flush or a held slot.
  always_comb begin
    hazard   = in_valid && (src_busy || waw);
    in_ready = !flush && !hazard &&
               (!out_valid || out_ready);
    issue    = in_valid && in_ready;
  end

  // Next slot contents with writeback forwarding.
  always_comb begin
    slot_d     = slot_q;
    slot_d.op  = op;
    slot_d.rd  = rd;
    slot_d.we  = we;
    slot_d.a   = (wb_valid && wb_rd == rf_rs1)
               ? wb_data : rf_rd1;
    slot_d.b   = (wb_valid && wb_rd == rf_rs2)
               ? wb_data : rf_rd2;
    slot_d.c   = (wb_valid && wb_rd == rf_rs3)
               ? wb_data : rf_rd3;
    slot_d.imm = in_instr[IMM_HI:IMM_LO];
  end

  // Slot occupancy: flush beats everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (issue) state_d = FULL;
      FULL: begin
        if (flush)          state_d = EMPTY;
        else if (issue)     state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Saturating hazard-stall counter.
  always_comb begin
    stall_d = stall_q;
    if (hazard && !flush && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // Slot payload loads only on issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       slot_q <= '0;
    else if (issue) slot_q <= slot_d;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign out_op    = slot_q.op;
  assign out_rd    = slot_q.rd;
  assign out_we    = slot_q.we;
  assign out_a     = slot_q.a;
  assign out_b     = slot_q.b;
  assign out_c     = slot_q.c;
  assign out_imm   = slot_q.imm;
  assign stall_cnt = stall_q;

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode/issue stage directly upstream of the 16×32 register file. It accepts instructions from fetch over a valid/ready handshake, decodes the source and destination fields, and drives the register-file read addresses. A 16-entry busy-bit scoreboard stalls issue on RAW and WAW hazards. Operands, with writeback forwarding, are registered into a single output slot for the execute stage. The writeback bus passes through this block to the register-file write port.

## Interface
- `XLEN`, default 32: data and instruction width.
- `NREG`, default 16: architectural register count (4-bit indices).
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `in_valid  in  1`, `in_instr  in  XLEN`, `in_ready  out  1`: fetch handshake.
- `rf_rs1`, `rf_rs2`, `rf_rs3  out  4`: register-file read addresses (combinational from `in_instr`).
- `rf_rd1`, `rf_rd2`, `rf_rd3  in  XLEN`: register-file read data (combinational).
- `rf_we  out  1`, `rf_waddr  out  4`, `rf_wdata  out  XLEN`: register-file write port, equal to `wb_valid`, `wb_rd`, `wb_data`.
- `wb_valid  in  1`, `wb_rd  in  4`, `wb_data  in  XLEN`: writeback from the last stage.
- `flush  in  1`: discard the pending input and the output slot.
- `out_valid  out  1`, `out_ready  in  1`: execute handshake.
- `out_op  out  4`, `out_rd  out  4`, `out_we  out  1`, `out_a`, `out_b`, `out_c  out  XLEN`, `out_imm  out  16`: issued instruction.
- `stall_cnt  out  16`: saturating count of hazard-stall cycles.

## Operation
- **Field layout:**
  - `op = instr[31:28]`, `rd = [27:24]`, `rs1 = [23:20]`, `rs2 = [19:16]`, `rs3 = [15:12]`, `imm = [15:0]`.
  - `writes_rd = (op <= 4'd11)`. Ops 12–15 (store, branch, nop, halt) do not write.
- **Operand selection:**
  - Each operand `x` is `wb_data` when `wb_valid && wb_rd == rs_x`. Otherwise it is `rf_rd_x`.
- **Hazards:**
  - `src_busy` is set when any of `rs1`/`rs2`/`rs3` has `busy[rs] && !(wb_valid && wb_rd == rs)`.
  - `waw` is set when `writes_rd && busy[rd] && !(wb_valid && wb_rd == rd)`.
  - `hazard = in_valid && (src_busy || waw)`.
- **Issue:**
  - `in_ready = !flush && !hazard && (!out_valid || out_ready)`.
  - Issue occurs on `in_valid && in_ready`. The output slot loads all fields, `out_valid` goes to 1, and `busy[rd]` is set if `writes_rd`.
- **Output slot:**
  - If `out_valid && out_ready` and there is no issue, `out_valid` goes to 0.
  - Slot contents are stable while `out_valid && !out_ready`.
- **Scoreboard update order in one cycle:**
  1. Clear `busy[wb_rd]` if `wb_valid`.
  2. Clear `busy[out_rd]` if flush discards a valid slot with `out_we`.
  3. Set `busy[rd]` on issue. Set wins on a same-index conflict.
- **Flush:**
  - `out_valid` goes to 0 and `in_ready` is 0 that cycle, so nothing issues.
  - Instructions already downstream still write back and clear their busy bits normally.
- **Stall counter:**
  - `stall_cnt` increments on each cycle with `hazard && !flush`.
  - It saturates at 16'hFFFF and never wraps.
- **States:** `EMPTY` (`out_valid = 0`) and `FULL` (`out_valid = 1`).
  - `EMPTY → FULL` on issue.
  - `FULL → EMPTY` on consume without issue, or on flush.
  - `FULL → FULL` on consume with simultaneous issue, or while held.

## Timing
- **Reset values:**
  - `out_valid = 0`, `busy = 0`, `stall_cnt = 0`.
  - `out_op`, `out_rd`, `out_we`, `out_a`, `out_b`, `out_c`, `out_imm` all 0.
- **Latency:** 1 cycle from issue edge to `out_valid`.
- **Throughput:** 1 instruction per cycle when there are no hazards and `out_ready` is held high.
- `in_ready`, `rf_rs*`, `rf_we`/`rf_waddr`/`rf_wdata` are combinational, with no registered path.
- The register file writes `wb_data` at the same edge that clears `busy`. Same-cycle forwarding therefore closes the one-cycle gap.
- Reset assertion mid-operation clears the slot and the scoreboard immediately (asynchronous). Deassertion takes effect at the next rising `clk`.

## Structure
- Package `decode_pkg` holds:
  - Field bit positions as localparams.
  - Opcode enum `op_e` (16 values).
  - Function `writes_rd(op_e)`.
  - Struct `issue_t {op, rd, we, a, b, c, imm}` used for the output slot.
- Sub-module `scoreboard` (16 busy bits, set/clear/flush-clear ports, 3 source lookups plus 1 destination lookup, each with writeback-bypass qualification).
  - Its outputs are `src_busy` and `waw`.
  - The top level holds decode, forwarding muxes, the output slot and `stall_cnt`.

## Test plan
- **Back-to-back independent ops:** after reset, issue ADD r1←r2,r3 then ADD r4←r5,r6 with `out_ready = 1` → `out_valid` high on cycles 1 and 2, `busy = 0x0012`, `stall_cnt = 0`.
- **RAW stall then forward:** issue r1←…, then r7←r1,r0,r0. Second op stalls (`in_ready = 0`). Then assert `wb_valid`, `wb_rd = 1`, `wb_data = 32'hDEAD_BEEF` → issues that cycle with `out_a = 32'hDEAD_BEEF`, `busy[1] = 0`, `stall_cnt` equal to the stall cycles.
- **WAW:** two writes to r3 with no writeback → second held; `busy[3]` stays 1 until `wb_rd = 3`, then second issues and `busy[3] = 1`.
- **Backpressure:** `out_ready = 0` with slot full → `in_ready = 0`; slot fields unchanged for 5 cycles; on `out_ready = 1` the next instruction loads the same cycle.
- **Flush:** slot holds r9-writer, assert `flush` → `out_valid = 0`, `busy[9] = 0`, no issue that cycle even with `in_valid = 1`.
- **Async reset mid-stall, saturation:** assert `rst = 0` between edges → `out_valid` and `busy` go to 0 immediately. Force 70000 stall cycles → `stall_cnt = 16'hFFFF`.
